// File: rtl/rng_arbiter_ctrl.sv
// Round-robin arbiter that fronts a single random_num_gen instance.
// One requester is granted at a time. The generator is started with a
// one-cycle pulse, its completion is awaited under a timeout, and the
// captured word is returned with the requester ID and an error flag.
module rng_arbiter_ctrl #(
  parameter int unsigned NBITS   = 2048,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 4095,
  localparam int unsigned IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             bypass_cfg,
  output logic             rsp_valid,
  output logic [IDW-1:0]   rsp_id,
  output logic [NBITS-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output logic             rng_enable_p,
  output logic             rng_bypass,
  input  logic [NBITS-1:0] rng_y,
  input  logic             rng_done_p
);

  // Abort fires on the WAIT cycle whose increment would reach TIMEOUT, so the
  // generator gets exactly TIMEOUT WAIT cycles.
  localparam logic [15:0] TmoLast  = 16'(TIMEOUT - 1);
  localparam logic [IDW-1:0] IdLast = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   last_id_q, last_id_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic             bypass_q, bypass_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [NBITS-1:0] rsp_data_q, rsp_data_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [IDW-1:0]   rr_id;

  // Round-robin pick: lowest requesting index above last_id, else wrap to the
  // lowest requesting index overall.
  always_comb begin
    logic           found_hi, found_lo;
    logic [IDW-1:0] pick_hi, pick_lo;
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int j = 0; j < int'(NREQ); j++) begin
      if (req[j] && (IDW'(j) > last_id_q) && !found_hi) begin
        found_hi = 1'b1;
        pick_hi  = IDW'(j);
      end
      if (req[j] && !found_lo) begin
        found_lo = 1'b1;
        pick_lo  = IDW'(j);
      end
    end
    rr_id = found_hi ? pick_hi : pick_lo;
  end

  // Next-state and datapath update for the grant/start/wait/respond sequence.
  always_comb begin
    state_d    = state_q;
    last_id_d  = last_id_q;
    grant_id_d = grant_id_q;
    bypass_d   = bypass_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          grant_id_d = rr_id;
          bypass_d   = bypass_cfg;
          state_d    = StStart;
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // Done takes precedence over a coincident timeout.
        if (rng_done_p) begin
          rsp_data_d = rng_y;
          err_d      = 1'b0;
          rsp_id_d   = grant_id_q;
          state_d    = StDone;
        end else if (cnt_q == TmoLast) begin
          rsp_data_d = '0;
          err_d      = 1'b1;
          rsp_id_d   = grant_id_q;
          state_d    = StDone;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StDone: begin
        last_id_d = grant_id_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      last_id_q  <= IdLast;
      grant_id_q <= '0;
      bypass_q   <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_id_q  <= last_id_d;
      grant_id_q <= grant_id_d;
      bypass_q   <= bypass_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  // Strobes decode directly from state; response fields hold between DONEs.
  always_comb begin
    rsp_valid    = (state_q == StDone);
    busy         = (state_q != StIdle);
    rng_enable_p = (state_q == StStart);
    rng_bypass   = bypass_q;
    rsp_id       = rsp_id_q;
    rsp_data     = rsp_data_q;
    rsp_err      = err_q;
  end

endmodule

// File: tb/tb_rng_arbiter_ctrl.sv
// Directed bench for rng_arbiter_ctrl with a simple generator model that
// pulses done five cycles after each enable pulse.
module tb_rng_arbiter_ctrl;

  localparam int unsigned NBITS   = 2048;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned IDW     = 2;

  logic             clk;
  logic             rst;
  logic [NREQ-1:0]  req;
  logic             bypass_cfg;
  logic             rsp_valid;
  logic [IDW-1:0]   rsp_id;
  logic [NBITS-1:0] rsp_data;
  logic             rsp_err;
  logic             busy;
  logic             rng_enable_p;
  logic             rng_bypass;
  logic [NBITS-1:0] rng_y;
  logic             rng_done_p;

  logic       model_on;
  logic       done_force;
  logic [2:0] cd = 3'd0;

  int checks = 0;
  int errors = 0;
  int ncyc;
  int nen;
  logic seen;
  int exp_ids [5] = '{0, 1, 2, 3, 0};

  rng_arbiter_ctrl #(
    .NBITS  (NBITS),
    .NREQ   (NREQ),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .bypass_cfg  (bypass_cfg),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .rng_enable_p(rng_enable_p),
    .rng_bypass  (rng_bypass),
    .rng_y       (rng_y),
    .rng_done_p  (rng_done_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generator model: done_p high in the fifth cycle after the enable cycle.
  always @(posedge clk) begin
    if (rng_enable_p === 1'b1 && model_on) cd <= 3'd5;
    else if (cd != 3'd0) cd <= cd - 3'd1;
  end
  assign rng_done_p = (cd == 3'd1) | done_force;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_data(input string tag, input logic [NBITS-1:0] obs,
                            input logic [NBITS-1:0] exp);
    logic [63:0] obs_lo;
    logic [63:0] exp_lo;
    obs_lo = obs[63:0];
    exp_lo = exp[63:0];
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed low64 %0h expected low64 %0h", tag, obs_lo, exp_lo);
    end
  endtask

  // Ticks until rsp_valid, counting cycles and enable pulses seen on the way.
  task automatic wait_rsp(input int max_cyc, output int n_cyc, output int n_en);
    n_cyc = 0;
    n_en  = 0;
    do begin
      tick();
      n_cyc++;
      if (rng_enable_p === 1'b1) n_en++;
    end while (rsp_valid !== 1'b1 && n_cyc < max_cyc);
    check_bit("rsp_valid_within_bound", rsp_valid, 1'b1);
  endtask

  initial begin
    rst        = 1'b1;
    req        = '0;
    bypass_cfg = 1'b0;
    done_force = 1'b0;
    model_on   = 1'b1;
    rng_y      = '0;
    tick();
    tick();

    // Reset state
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_valid", rsp_valid, 1'b0);
    check_bit("reset_enable", rng_enable_p, 1'b0);
    check_bit("reset_bypass", rng_bypass, 1'b0);
    check_data("reset_data", rsp_data, '0);
    rst = 1'b0;

    // All requesters held: service order 0,1,2,3,0
    rng_y = NBITS'(42);
    req   = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(40, ncyc, nen);
      check_int("rr_id", int'(rsp_id), exp_ids[k]);
      check_int("rr_enables_per_rsp", nen, 1);
      if (k > 0) check_int("rr_period", ncyc, 8);
    end
    req = '0;
    tick();
    check_bit("rr_idle_after", busy, 1'b0);

    // Single request, normal completion
    rng_y = NBITS'(1093);
    req   = 4'b0100;
    tick();
    check_bit("t1_enable", rng_enable_p, 1'b1);
    check_bit("t1_busy", busy, 1'b1);
    req = '0;
    wait_rsp(40, ncyc, nen);
    check_int("t1_latency", ncyc, 6);
    check_int("t1_single_enable", nen, 0);
    check_int("t1_id", int'(rsp_id), 2);
    check_data("t1_data", rsp_data, NBITS'(1093));
    check_bit("t1_err", rsp_err, 1'b0);
    tick();
    check_bit("t1_busy_after", busy, 1'b0);
    check_bit("t1_valid_one_cycle", rsp_valid, 1'b0);
    check_data("t1_data_hold", rsp_data, NBITS'(1093));

    // Timeout: generator silent
    model_on = 1'b0;
    req      = 4'b0001;
    tick();
    req = '0;
    wait_rsp(40, ncyc, nen);
    check_int("tmo_latency", ncyc, 16);
    check_bit("tmo_err", rsp_err, 1'b1);
    check_data("tmo_data", rsp_data, '0);
    check_int("tmo_id", int'(rsp_id), 0);
    model_on = 1'b1;
    tick();
    rng_y = NBITS'(32'hABCD);
    req   = 4'b0010;
    tick();
    req = '0;
    wait_rsp(40, ncyc, nen);
    check_int("post_tmo_id", int'(rsp_id), 1);
    check_bit("post_tmo_err", rsp_err, 1'b0);
    check_data("post_tmo_data", rsp_data, NBITS'(32'hABCD));

    // Done coincides with the timeout cycle: done wins
    model_on = 1'b0;
    tick();
    req = 4'b0001;
    tick();
    req = '0;
    repeat (15) tick();
    check_bit("coinc_not_yet", rsp_valid, 1'b0);
    done_force = 1'b1;
    rng_y      = NBITS'(555);
    tick();
    done_force = 1'b0;
    check_bit("coinc_valid", rsp_valid, 1'b1);
    check_bit("coinc_err", rsp_err, 1'b0);
    check_data("coinc_data", rsp_data, NBITS'(555));
    model_on = 1'b1;

    // Reset two cycles into WAIT; the late done must be ignored
    tick();
    bypass_cfg = 1'b1;
    req        = 4'b0100;
    tick();
    bypass_cfg = 1'b0;
    req        = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_bit("rst_valid", rsp_valid, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_enable", rng_enable_p, 1'b0);
    check_bit("rst_bypass", rng_bypass, 1'b0);
    check_bit("rst_err", rsp_err, 1'b0);
    check_int("rst_id", int'(rsp_id), 0);
    check_data("rst_data", rsp_data, '0);
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    check_bit("rst_late_done_ignored", seen, 1'b0);
    rng_y = NBITS'(777);
    req   = 4'b1000;
    tick();
    req = '0;
    wait_rsp(40, ncyc, nen);
    check_int("post_rst_id", int'(rsp_id), 3);
    check_data("post_rst_data", rsp_data, NBITS'(777));

    // Spurious done while idle
    tick();
    rng_y      = NBITS'(1999);
    done_force = 1'b1;
    tick();
    done_force = 1'b0;
    check_bit("spur_valid", rsp_valid, 1'b0);
    check_bit("spur_busy", busy, 1'b0);
    check_data("spur_data", rsp_data, NBITS'(777));
    tick();
    check_bit("spur_valid_next", rsp_valid, 1'b0);
    check_bit("spur_busy_next", busy, 1'b0);

    // Bypass latched at grant, held until the next grant
    bypass_cfg = 1'b1;
    req        = 4'b0001;
    tick();
    check_bit("byp_start", rng_bypass, 1'b1);
    bypass_cfg = 1'b0;
    req        = '0;
    tick();
    tick();
    check_bit("byp_wait", rng_bypass, 1'b1);
    wait_rsp(40, ncyc, nen);
    check_bit("byp_done", rng_bypass, 1'b1);
    check_data("byp_data", rsp_data, NBITS'(1999));
    req = 4'b0010;
    tick();
    check_bit("byp_hold_idle", rng_bypass, 1'b1);
    tick();
    check_bit("byp_regrant", rng_bypass, 1'b0);
    req = '0;
    wait_rsp(40, ncyc, nen);
    check_int("byp_next_id", int'(rsp_id), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
